// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding,
// default latencies and the two-state control encoding.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MFHI  = 4'd7,
        MFLO  = 4'd8
    } mdop_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: holds HI/LO, computes the result at issue and
// commits it after a fixed busy period.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [31:0]        pend_hi, pend_hi_next;
    logic [31:0]        pend_lo, pend_lo_next;
    logic               pend_wr, pend_wr_next;
    logic [31:0]        hi_next, lo_next;

    logic signed [63:0] a_s, b_s, bd_s;
    logic        [63:0] a_u, b_u, bd_u;
    logic        [63:0] prod_s, prod_u;
    logic        [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        [31:0] res_hi, res_lo;
    logic               is_div;

    assign a_s = {{32{rs[31]}}, rs};
    assign b_s = {{32{rt[31]}}, rt};
    assign a_u = {32'd0, rs};
    assign b_u = {32'd0, rt};

    // Zero divisor is replaced by one so the divider never sees it; the
    // result is discarded at commit anyway.
    assign bd_s = (rt == 32'd0) ? 64'sd1 : b_s;
    assign bd_u = (rt == 32'd0) ? 64'd1  : b_u;

    assign prod_s = 64'(a_s * b_s);
    assign prod_u = a_u * b_u;
    assign quot_s = 32'(a_s / bd_s);
    assign rem_s  = 32'(a_s % bd_s);
    assign quot_u = 32'(a_u / bd_u);
    assign rem_u  = 32'(a_u % bd_u);

    assign is_div = (mdop == DIV) || (mdop == DIVU);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (mdop)
            MULT:    begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            MULTU:   begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            DIV:     begin res_hi = rem_s;         res_lo = quot_s;       end
            DIVU:    begin res_hi = rem_u;         res_lo = quot_u;       end
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pend_hi_next = pend_hi;
        pend_lo_next = pend_lo;
        pend_wr_next = pend_wr;
        hi_next      = hi;
        lo_next      = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mdop)
                        MULT, MULTU, DIV, DIVU: begin
                            pend_hi_next = res_hi;
                            pend_lo_next = res_lo;
                            pend_wr_next = !(is_div && (rt == 32'd0));
                            cnt_next     = is_div ? CNT_W'(DIV_CYCLES)
                                                  : CNT_W'(MULT_CYCLES);
                            state_next   = BUSY;
                        end
                        MTHI:    hi_next = rs;
                        MTLO:    lo_next = rs;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    if (pend_wr) begin
                        hi_next = pend_hi;
                        lo_next = pend_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pend_hi <= pend_hi_next;
            pend_lo <= pend_lo_next;
            pend_wr <= pend_wr_next;
            hi      <= hi_next;
            lo      <= lo_next;
        end
    end

    assign busy = (state == BUSY);

    always_comb begin
        md_out = 32'd0;
        if (mdop == MFHI) md_out = hi;
        else if (mdop == MFLO) md_out = lo;
    end

endmodule
